rf_scoreboard: RTL and testbench
================================

// Module: rf_scoreboard
// PURPOSE
//  Per-register in-flight-write scoreboard for the pipelined core; replaces per-stage waddr compare interlock.
//  ID queries NUM_RD source regs and gets busy/stall; issue of a writing inst increments its dest counter.
//  WB retire, or a pipeline kill (branch cancel/flush), decrements it. Counters allow multiple outstanding writes per reg.
// PARAMETERS
//  NUM_RD        2  number of register read (query) ports
//  NUM_KILL      2  number of kill ports (one per killable in-flight stage)
//  CNT_W         2  counter width; max outstanding writes per reg = 2**CNT_W-1
//  RETIRE_BYPASS 0  1: reg whose only pending write retires this cycle reads as not busy
// PORTS
//  clk           in   1            clock, rising edge
//  resetn        in   1            asynchronous active-low reset
//  rd_en         in   NUM_RD       per-port query enable
//  rd_addr       in   NUM_RD*5     per-port source reg, port i at [5i+4:5i]
//  rd_busy       out  NUM_RD       port i reg has pending write (0 if !rd_en[i] or addr 0)
//  stall         out  1            |rd_busy | (issue_valid & issue_we & dest counter saturated)
//  issue_valid   in   1            ID offering an instruction
//  issue_we      in   1            instruction writes a reg
//  issue_waddr   in   5            destination reg
//  issue_fire    out  1            issue_valid & ~stall; scoreboard update takes effect this edge
//  retire_valid  in   1            WB committing a reg write this cycle
//  retire_waddr  in   5            reg being written
//  kill_valid    in   NUM_KILL     kill of an in-flight writing inst
//  kill_waddr    in   NUM_KILL*5   its destination reg
//  busy_mask     out  32           bit r = (cnt[r] != 0); bit 0 always 0
//  err           out  1            sticky: decrement requested on zero counter
// BEHAVIOUR
//  State: cnt[1..31], CNT_W bits each; cnt[0] not stored, reads as 0. err flop.
//  Reset (resetn=0, async): all cnt=0, err=0 -> rd_busy=0, stall=0, busy_mask=0, issue_fire=issue_valid.
//  Query (combinational from registered cnt, zero latency):
//   rd_busy[i] = rd_en[i] & addr!=0 & (cnt[addr]!=0)
//   RETIRE_BYPASS=1: also cleared when cnt[addr]==1 & net decrement on addr this cycle >=1.
//   RETIRE_BYPASS=0: no same-cycle bypass; regfile writes at the edge and ID reads next cycle.
//  Saturation: issue_we & waddr!=0 & cnt[waddr]==2**CNT_W-1 forces stall; counter never wraps.
//  Update per edge, per reg r != 0:
//   inc = issue_fire & issue_we & issue_waddr==r
//   dec = (retire_valid & retire_waddr==r) + count of kill ports with kill_valid & kill_waddr==r
//   cnt[r] <= cnt[r] + inc - dec, computed in CNT_W+2 bits.
//   If the result < 0: cnt[r] <= 0, err <= 1. err clears only on reset.
//  Simultaneous events:
//   Issue, retire and kills on the same reg sum into one net delta; e.g. cnt=1, inc+retire -> 1.
//   Writes to reg 0 (issue, retire, kill) are ignored and never set err.
//  Kill ports are independent of issue; a kill in the same cycle as issue of a different reg updates both.
//  Reset mid-operation clears everything immediately; in-flight insts are assumed flushed by the same reset.
//  No handshake state beyond counters: ID holds issue_valid/operands while stall=1.
// TESTING
//  1 Reset: resetn low mid-run with cnt[5]=2 -> busy_mask=0, err=0, stall=0 asynchronously, before any clk edge.
//  2 RAW: issue r3 we; next cycle rd_addr0=3 -> rd_busy[0]=1, stall=1; retire r3 -> following cycle rd_busy[0]=0.
//  3 WAW: issue r7 twice -> cnt=2; one retire -> still busy; second retire -> busy_mask[7]=0.
//  4 Saturation: CNT_W=2, issue r9 three times -> 4th issue with we to r9: stall=1, issue_fire=0, cnt stays 3.
//  5 Same-cycle mix: cnt[4]=1, issue r4 + retire r4 + kill r4 -> cnt[4]=0, err=0;
//    RETIRE_BYPASS=1 with cnt[2]=1, retire r2, query r2 -> rd_busy=0 that cycle.
//  6 Error/r0: retire r6 with cnt[6]=0 -> err=1 sticky, cnt stays 0;
//    issue/query/retire r0 -> no busy, no err.

Source files
------------

// File: rtl/rf_scoreboard_if.sv
// Scoreboard bus: ID source queries, issue handshake, WB retire, pipeline kills,
// plus the status outputs. The pipeline side is master, the scoreboard is slave.
interface rf_scoreboard_if #(
  parameter int NUM_RD   = 2,
  parameter int NUM_KILL = 2
);
  logic [NUM_RD-1:0]     rd_en;
  logic [NUM_RD*5-1:0]   rd_addr;
  logic [NUM_RD-1:0]     rd_busy;
  logic                  stall;
  logic                  issue_valid;
  logic                  issue_we;
  logic [4:0]            issue_waddr;
  logic                  issue_fire;
  logic                  retire_valid;
  logic [4:0]            retire_waddr;
  logic [NUM_KILL-1:0]   kill_valid;
  logic [NUM_KILL*5-1:0] kill_waddr;
  logic [31:0]           busy_mask;
  logic                  err;

  modport master (
    output rd_en, rd_addr, issue_valid, issue_we, issue_waddr,
           retire_valid, retire_waddr, kill_valid, kill_waddr,
    input  rd_busy, stall, issue_fire, busy_mask, err
  );

  modport slave (
    input  rd_en, rd_addr, issue_valid, issue_we, issue_waddr,
           retire_valid, retire_waddr, kill_valid, kill_waddr,
    output rd_busy, stall, issue_fire, busy_mask, err
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register in-flight-write scoreboard. Each architectural register r (1..31)
// keeps a saturating count of issued-but-not-retired writes. Issue increments,
// WB retire and pipeline kills decrement; all events on one register in a cycle
// fold into a single net delta. Register 0 is hardwired idle.
module rf_scoreboard #(
  parameter int NUM_RD        = 2,
  parameter int NUM_KILL      = 2,
  parameter int CNT_W         = 2,
  parameter bit RETIRE_BYPASS = 1'b0
) (
  input logic              clk,
  input logic              resetn,
  rf_scoreboard_if.slave   sb_if
);

  // Extra headroom so cnt + inc - dec can be examined for underflow.
  localparam int DW = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0]  cnt_q   [1:31];
  logic [CNT_W-1:0]  cnt_d   [1:31];
  logic              err_q;
  logic              err_d;
  logic [CNT_W-1:0]  cnt_all [0:31];
  logic [DW-1:0]     dec_cnt [0:31];
  logic [31:1]       inc_vec;
  logic [NUM_RD-1:0] rd_busy_c;
  logic [4:0]        rd_a;
  logic              sat_hit;
  logic              stall_c;
  logic              fire_c;
  logic [DW-1:0]     up_c;
  logic [31:0]       busy_mask_c;

  // Uniform view of all 32 counters with reg 0 pinned to zero
  always_comb begin
    cnt_all[0] = '0;
    for (int r = 1; r < 32; r++) cnt_all[r] = cnt_q[r];
  end

  // Count decrement sources (retire plus each kill port) per register
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      dec_cnt[r] = '0;
      if (r != 0) begin
        if (sb_if.retire_valid && sb_if.retire_waddr == 5'(r))
          dec_cnt[r] = dec_cnt[r] + DW'(1);
        for (int k = 0; k < NUM_KILL; k++) begin
          if (sb_if.kill_valid[k] && sb_if.kill_waddr[5*k +: 5] == 5'(r))
            dec_cnt[r] = dec_cnt[r] + DW'(1);
        end
      end
    end
  end

  // Source-operand busy query. The bypass only looks at decrements: the
  // instruction being issued is the reader, so its own increment never
  // hides a hazard on its sources (and this keeps stall free of loops).
  always_comb begin
    rd_busy_c = '0;
    rd_a      = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_a = sb_if.rd_addr[5*i +: 5];
      rd_busy_c[i] = sb_if.rd_en[i] && (rd_a != 5'd0) && (cnt_all[rd_a] != '0);
      if (RETIRE_BYPASS && (cnt_all[rd_a] == CNT_W'(1)) && (dec_cnt[rd_a] != '0))
        rd_busy_c[i] = 1'b0;
    end
  end

  // Stall on a source hazard or on a destination counter that cannot grow
  always_comb begin
    sat_hit = sb_if.issue_valid && sb_if.issue_we && (sb_if.issue_waddr != 5'd0) &&
              (cnt_all[sb_if.issue_waddr] == CNT_MAX);
    stall_c = (|rd_busy_c) || sat_hit;
    fire_c  = sb_if.issue_valid && !stall_c;
  end

  // Per-register increment from an accepted writing instruction
  always_comb begin
    inc_vec = '0;
    for (int r = 1; r < 32; r++)
      inc_vec[r] = fire_c && sb_if.issue_we && (sb_if.issue_waddr == 5'(r));
  end

  // Net update per register; underflow clamps to zero and flags err
  always_comb begin
    err_d = err_q;
    up_c  = '0;
    for (int r = 1; r < 32; r++) begin
      up_c = DW'(cnt_q[r]) + DW'(inc_vec[r]);
      if (up_c < dec_cnt[r]) begin
        cnt_d[r] = '0;
        err_d    = 1'b1;
      end else begin
        cnt_d[r] = CNT_W'(up_c - dec_cnt[r]);
      end
    end
  end

  // Counter and sticky error state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 1; r < 32; r++) cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 1; r < 32; r++) cnt_q[r] <= cnt_d[r];
      err_q <= err_d;
    end
  end

  // Occupancy bitmap for debug and flush logic
  always_comb begin
    busy_mask_c = '0;
    for (int r = 1; r < 32; r++) busy_mask_c[r] = (cnt_all[r] != '0);
  end

  assign sb_if.rd_busy    = rd_busy_c;
  assign sb_if.stall      = stall_c;
  assign sb_if.issue_fire = fire_c;
  assign sb_if.busy_mask  = busy_mask_c;
  assign sb_if.err        = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard. Two instances share one stimulus stream:
// u_dut without retire bypass, u_byp with it.
module tb_rf_scoreboard;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  rf_scoreboard_if #(.NUM_RD(2), .NUM_KILL(2)) if0 ();
  rf_scoreboard_if #(.NUM_RD(2), .NUM_KILL(2)) if1 ();

  rf_scoreboard #(.NUM_RD(2), .NUM_KILL(2), .CNT_W(2), .RETIRE_BYPASS(1'b0)) u_dut (
    .clk(clk), .resetn(resetn), .sb_if(if0)
  );
  rf_scoreboard #(.NUM_RD(2), .NUM_KILL(2), .CNT_W(2), .RETIRE_BYPASS(1'b1)) u_byp (
    .clk(clk), .resetn(resetn), .sb_if(if1)
  );

  assign if1.rd_en        = if0.rd_en;
  assign if1.rd_addr      = if0.rd_addr;
  assign if1.issue_valid  = if0.issue_valid;
  assign if1.issue_we     = if0.issue_we;
  assign if1.issue_waddr  = if0.issue_waddr;
  assign if1.retire_valid = if0.retire_valid;
  assign if1.retire_waddr = if0.retire_waddr;
  assign if1.kill_valid   = if0.kill_valid;
  assign if1.kill_waddr   = if0.kill_waddr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // compare observed against expected and log any mismatch
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    if0.rd_en        = '0;
    if0.rd_addr      = '0;
    if0.issue_valid  = 1'b0;
    if0.issue_we     = 1'b0;
    if0.issue_waddr  = '0;
    if0.retire_valid = 1'b0;
    if0.retire_waddr = '0;
    if0.kill_valid   = '0;
    if0.kill_waddr   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] a);
    idle();
    if0.issue_valid = 1'b1;
    if0.issue_we    = 1'b1;
    if0.issue_waddr = a;
  endtask

  task automatic retire(input logic [4:0] a);
    idle();
    if0.retire_valid = 1'b1;
    if0.retire_waddr = a;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    idle();

    // reset values, issue_fire follows issue_valid while held in reset
    if0.issue_valid = 1'b1;
    if0.issue_we    = 1'b1;
    if0.issue_waddr = 5'd5;
    #2;
    chk("rst_mask", if0.busy_mask, 32'h0);
    chk("rst_err", if0.err, 1'b0);
    chk("rst_stall", if0.stall, 1'b0);
    chk("rst_fire", if0.issue_fire, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    idle();
    tick();

    // RAW on r3
    issue(5'd3);
    @(negedge clk);
    chk("raw_fire", if0.issue_fire, 1'b1);
    tick();
    idle();
    if0.rd_en = 2'b01;
    if0.rd_addr = {5'd0, 5'd3};
    if0.issue_valid = 1'b1;
    @(negedge clk);
    chk("raw_busy", if0.rd_busy, 2'b01);
    chk("raw_stall", if0.stall, 1'b1);
    chk("raw_nofire", if0.issue_fire, 1'b0);
    tick();
    if0.retire_valid = 1'b1;
    if0.retire_waddr = 5'd3;
    @(negedge clk);
    chk("raw_nobyp_busy", if0.rd_busy, 2'b01);
    chk("raw_byp_busy", if1.rd_busy, 2'b00);
    chk("raw_byp_stall", if1.stall, 1'b0);
    tick();
    if0.retire_valid = 1'b0;
    @(negedge clk);
    chk("raw_clear_busy", if0.rd_busy, 2'b00);
    chk("raw_clear_mask", if0.busy_mask, 32'h0);
    tick();

    // WAW on r7, port 1 query
    issue(5'd7);
    tick();
    issue(5'd7);
    tick();
    retire(5'd7);
    @(negedge clk);
    chk("waw_mask2", if0.busy_mask, 32'h80);
    tick();
    retire(5'd7);
    if0.rd_en = 2'b10;
    if0.rd_addr = {5'd7, 5'd0};
    @(negedge clk);
    chk("waw_mask1", if0.busy_mask, 32'h80);
    chk("waw_busy_p1", if0.rd_busy, 2'b10);
    chk("waw_byp_p1", if1.rd_busy, 2'b00);
    tick();
    idle();
    @(negedge clk);
    chk("waw_mask0", if0.busy_mask, 32'h0);

    // saturation on r9
    for (int n = 0; n < 3; n++) begin
      tick();
      issue(5'd9);
    end
    tick();
    issue(5'd9);
    @(negedge clk);
    chk("sat_mask", if0.busy_mask, 32'h200);
    chk("sat_stall", if0.stall, 1'b1);
    chk("sat_nofire", if0.issue_fire, 1'b0);
    tick();
    if0.issue_we = 1'b0;
    @(negedge clk);
    chk("sat_nowe_stall", if0.stall, 1'b0);
    chk("sat_nowe_fire", if0.issue_fire, 1'b1);
    tick();
    retire(5'd9);
    tick();
    retire(5'd9);
    @(negedge clk);
    chk("sat_after2_mask", if0.busy_mask, 32'h200);
    tick();
    retire(5'd9);
    tick();
    idle();
    @(negedge clk);
    chk("sat_drain_mask", if0.busy_mask, 32'h0);
    chk("sat_drain_err", if0.err, 1'b0);

    // same-cycle mix on r4: +1 -1 -1 from cnt 1 -> 0
    tick();
    issue(5'd4);
    tick();
    issue(5'd4);
    if0.retire_valid = 1'b1;
    if0.retire_waddr = 5'd4;
    if0.kill_valid = 2'b01;
    if0.kill_waddr = {5'd0, 5'd4};
    @(negedge clk);
    chk("mix_fire", if0.issue_fire, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk("mix_mask", if0.busy_mask, 32'h0);
    chk("mix_err", if0.err, 1'b0);

    // kill of r11 alongside issue of r10
    tick();
    issue(5'd11);
    tick();
    issue(5'd10);
    if0.kill_valid = 2'b10;
    if0.kill_waddr = {5'd11, 5'd0};
    tick();
    retire(5'd12);
    if0.issue_valid = 1'b1;
    if0.issue_we = 1'b1;
    if0.issue_waddr = 5'd12;
    if0.retire_valid = 1'b0;
    @(negedge clk);
    chk("kill_mask", if0.busy_mask, 32'h400);
    tick();
    // issue + retire on r12 with cnt 1 -> stays 1
    issue(5'd12);
    if0.retire_valid = 1'b1;
    if0.retire_waddr = 5'd12;
    tick();
    retire(5'd10);
    @(negedge clk);
    chk("incret_mask", if0.busy_mask, 32'h1400);
    tick();
    retire(5'd12);
    tick();
    idle();
    @(negedge clk);
    chk("incret_drain", if0.busy_mask, 32'h0);

    // r0 traffic is ignored
    tick();
    idle();
    if0.issue_valid = 1'b1;
    if0.issue_we = 1'b1;
    if0.issue_waddr = 5'd0;
    if0.retire_valid = 1'b1;
    if0.retire_waddr = 5'd0;
    if0.kill_valid = 2'b11;
    if0.rd_en = 2'b11;
    if0.rd_addr = '0;
    @(negedge clk);
    chk("r0_busy", if0.rd_busy, 2'b00);
    chk("r0_fire", if0.issue_fire, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk("r0_err", if0.err, 1'b0);
    chk("r0_mask", if0.busy_mask, 32'h0);

    // underflow on r6 sets sticky err
    tick();
    retire(5'd6);
    tick();
    idle();
    @(negedge clk);
    chk("uf_err", if0.err, 1'b1);
    chk("uf_mask", if0.busy_mask, 32'h0);
    tick();
    issue(5'd6);
    tick();
    idle();
    @(negedge clk);
    chk("uf_cnt_zero", if0.busy_mask, 32'h40);
    chk("uf_sticky", if0.err, 1'b1);
    tick();
    retire(5'd6);
    tick();
    idle();
    @(negedge clk);
    chk("uf_drain", if0.busy_mask, 32'h0);
    chk("byp_err", if1.err, 1'b1);

    // asynchronous reset mid-run with cnt[5]=2
    tick();
    issue(5'd5);
    tick();
    issue(5'd5);
    tick();
    idle();
    if0.rd_en = 2'b01;
    if0.rd_addr = {5'd0, 5'd5};
    if0.issue_valid = 1'b1;
    @(negedge clk);
    chk("pre_rst_mask", if0.busy_mask, 32'h20);
    chk("pre_rst_stall", if0.stall, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_mask", if0.busy_mask, 32'h0);
    chk("arst_err", if0.err, 1'b0);
    chk("arst_stall", if0.stall, 1'b0);
    chk("arst_fire", if0.issue_fire, 1'b1);
    chk("arst_byp_mask", if1.busy_mask, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    idle();
    tick();
    @(negedge clk);
    chk("post_rst_mask", if0.busy_mask, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
